// File: rtl/cordic_polar_iter_if.sv
// cordic_polar_iter_if: interleaved magnitude/phase input and I/Q output stream
interface cordic_polar_iter_if #(
    parameter int dw = 18
);
    logic [dw-1:0] in_mp;
    logic          in_phase;
    logic          in_valid;
    logic          clr_ovr;
    logic [dw-1:0] out_iq;
    logic          out_phase;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    modport master (
        output in_mp, in_phase, in_valid, clr_ovr,
        input  out_iq, out_phase, out_valid, busy, overrun
    );

    modport slave (
        input  in_mp, in_phase, in_valid, clr_ovr,
        output out_iq, out_phase, out_valid, busy, overrun
    );
endinterface

// File: rtl/cordic_polar_iter.sv
// cordic_polar_iter: iterative polar-to-rectangular CORDIC, one micro-rotation per clock
module cordic_polar_iter #(
    parameter int dw   = 18,
    parameter int nstg = 18
) (
    input logic clk,
    input logic rst,
    cordic_polar_iter_if.slave io
);
    localparam int zw = dw + 2;
    localparam int xw = dw + 3;
    localparam int cw = $clog2(nstg + 1);
    localparam logic signed [xw-1:0] lim = xw'((64'sd1 <<< (dw - 1)) - 64'sd1);

    typedef enum logic [2:0] {IDLE, HAVE_MAG, ROTATE, OUT_I, OUT_Q} state_t;

    // atan(2^-i) in turns scaled by 2^zw, summed from the alternating power series in Q62
    function automatic logic [zw-1:0] atan_c(input int i);
        longint a, t, p;
        if (i == 0) return zw'(64'd1 << (zw - 3));
        a = 0;
        for (int k = 0; i * (2 * k + 1) <= 62; k++) begin
            t = (64'sd1 <<< (62 - i * (2 * k + 1))) / longint'(2 * k + 1);
            a = (k % 2 == 0) ? a + t : a - t;
        end
        p = (a >>> 30) * 64'sh28BE60DC;
        return zw'((p + (64'sd1 <<< (63 - zw))) >>> (64 - zw));
    endfunction

    // drop the guard bits, then clamp symmetrically
    function automatic logic [dw-1:0] sat(input logic signed [xw-1:0] v);
        logic signed [xw-1:0] q;
        q = v >>> 2;
        return (q > lim) ? lim[dw-1:0] : (q < -lim) ? dw'(-lim) : q[dw-1:0];
    endfunction

    logic [zw-1:0] atan_tab [nstg+1];

    for (genvar s = 0; s <= nstg; s++) begin : g_atan
        localparam logic [zw-1:0] a = atan_c(s);
        assign atan_tab[s] = a;
    end

    state_t               state;
    logic signed [dw-1:0] mag;
    logic signed [xw-1:0] x, y, mx, x0, xs, ys;
    logic        [zw-1:0] z, z0, at;
    logic        [cw-1:0] cnt;
    logic                 flip, neg;

    // fold the phase into the right half-plane and form the current micro-rotation terms
    always_comb begin
        flip = io.in_mp[dw-1] ^ io.in_mp[dw-2];
        mx   = xw'(mag) <<< 2;
        x0   = flip ? -mx : mx;
        z0   = {io.in_mp[dw-1] ^ flip, io.in_mp[dw-2:0], 2'b00};
        neg  = z[zw-1];
        xs   = x >>> cnt;
        ys   = y >>> cnt;
        at   = atan_tab[cnt];
    end

    // control FSM with the x/y/z datapath and registered I/Q outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            io.out_iq    <= '0;
            io.out_phase <= 1'b0;
            io.out_valid <= 1'b0;
            io.overrun   <= 1'b0;
        end else begin
            io.out_valid <= 1'b0;
            if (io.in_valid && (state == ROTATE || state == OUT_I || state == OUT_Q))
                io.overrun <= 1'b1;
            else if (io.clr_ovr)
                io.overrun <= 1'b0;
            case (state)
                IDLE: if (io.in_valid && !io.in_phase) begin
                    mag   <= io.in_mp;
                    state <= HAVE_MAG;
                end
                HAVE_MAG: if (!io.in_valid) begin
                    state <= IDLE;
                end else if (!io.in_phase) begin
                    mag <= io.in_mp;
                end else begin
                    x     <= x0;
                    y     <= '0;
                    z     <= z0;
                    cnt   <= '0;
                    state <= ROTATE;
                end
                ROTATE: if (cnt == cw'(nstg)) begin
                    io.out_iq    <= sat(x);
                    io.out_phase <= 1'b0;
                    io.out_valid <= 1'b1;
                    state        <= OUT_I;
                end else begin
                    x   <= neg ? x + ys : x - ys;
                    y   <= neg ? y - xs : y + xs;
                    z   <= neg ? z + at : z - at;
                    cnt <= cnt + 1'b1;
                end
                OUT_I: begin
                    io.out_iq    <= sat(y);
                    io.out_phase <= 1'b1;
                    io.out_valid <= 1'b1;
                    state        <= OUT_Q;
                end
                OUT_Q: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign io.busy = state != IDLE;
endmodule

// File: tb/tb_cordic_polar_iter.sv
// tb_cordic_polar_iter: directed and randomized conversions against a floating-point polar model
module tb_cordic_polar_iter;
    localparam int DW   = 18;
    localparam int NSTG = 18;
    localparam int LIM  = (1 << (DW - 1)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    real  kg;
    int   oq[$], pq[$], bq[$], cq[$];
    int   tp, m;
    logic signed [DW-1:0] p;
    int   dm[7] = '{50000, 50000, 50000, 50000, -50000, 100000, 100000};
    int   dp[7] = '{0, 65536, 131072, -32768, 0, 0, 131072};

    cordic_polar_iter_if #(.dw(DW)) io();

    cordic_polar_iter #(.dw(DW), .nstg(NSTG)) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // record every output word with its cycle stamp and the busy level alongside it
    always @(negedge clk) begin
        if (io.out_valid) begin
            oq.push_back(int'($signed(io.out_iq)));
            pq.push_back(int'(io.out_phase));
            bq.push_back(int'(io.busy));
            cq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp, input int tol = 0);
        int d;
        d = got - exp;
        n_vec++;
        if (d > tol || d < -tol) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit v, input bit ph, input int w);
        io.in_valid = v;
        io.in_phase = ph;
        io.in_mp    = w[DW-1:0];
    endtask

    function automatic int clip(input real r);
        if (r > LIM) return LIM;
        if (r < -LIM) return -LIM;
        return int'(r);
    endfunction

    function automatic void model(input int mag, input int ph, output int ei, output int eq);
        real a;
        a  = 2.0 * 3.14159265358979 * real'(ph) / real'(1 << DW);
        ei = clip(kg * real'(mag) * $cos(a));
        eq = clip(kg * real'(mag) * $sin(a));
    endfunction

    task automatic start(input int mag, input int ph, input int pre, output int t);
        oq.delete();
        pq.delete();
        bq.delete();
        cq.delete();
        if (pre != 0) begin
            drive(1'b1, 1'b0, pre);
            tick();
        end
        drive(1'b1, 1'b0, mag);
        tick();
        drive(1'b1, 1'b1, ph);
        tick();
        t = cyc;
        drive(1'b0, 1'b0, 0);
    endtask

    task automatic collect(input string tag, input int mag, input int ph, input int t, input int extra);
        int ei, eq;
        model(mag, ph, ei, eq);
        for (int k = 0; k < NSTG + 10 && oq.size() < 2; k++) tick();
        check({tag, "_busy_end"}, int'(io.busy), 0);
        tick(extra);
        check({tag, "_nout"}, oq.size(), 2);
        if (oq.size() >= 2) begin
            check({tag, "_tI"}, cq[0] - t, NSTG + 1);
            check({tag, "_phI"}, pq[0], 0);
            check({tag, "_I"}, oq[0], ei, 4);
            check({tag, "_busyI"}, bq[0], 1);
            check({tag, "_tQ"}, cq[1] - t, NSTG + 2);
            check({tag, "_phQ"}, pq[1], 1);
            check({tag, "_Q"}, oq[1], eq, 4);
            check({tag, "_busyQ"}, bq[1], 1);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        kg = 1.0;
        for (int i = 0; i < NSTG; i++) kg = kg * $sqrt(1.0 + 1.0 / real'(longint'(1) << (2 * i)));
        drive(1'b0, 1'b0, 0);
        io.clr_ovr = 1'b0;
        tick(2);
        rst = 1'b0;
        check("rst_iq", int'(io.out_iq), 0);
        check("rst_phase", int'(io.out_phase), 0);
        check("rst_valid", int'(io.out_valid), 0);
        check("rst_busy", int'(io.busy), 0);
        check("rst_ovr", int'(io.overrun), 0);

        for (int i = 0; i < 7; i++) begin
            start(dm[i], dp[i], 0, tp);
            collect($sformatf("dir%0d", i), dm[i], dp[i], tp, 3);
        end

        oq.delete();
        drive(1'b1, 1'b0, 30000);
        tick();
        check("hm_busy", int'(io.busy), 1);
        drive(1'b0, 1'b0, 0);
        tick();
        check("hm_drop", int'(io.busy), 0);
        tick(NSTG + 4);
        check("hm_nout", oq.size(), 0);

        drive(1'b1, 1'b1, 1000);
        tick();
        drive(1'b0, 1'b0, 0);
        check("ph_idle_busy", int'(io.busy), 0);
        check("ph_idle_ovr", int'(io.overrun), 0);

        start(50000, 20000, -70000, tp);
        collect("resync", 50000, 20000, tp, 3);

        start(40000, 10000, 0, tp);
        tick(3);
        drive(1'b1, 1'b0, 90000);
        tick();
        drive(1'b1, 1'b1, -50000);
        tick();
        drive(1'b0, 1'b0, 0);
        check("ovr_set", int'(io.overrun), 1);
        collect("ovr", 40000, 10000, tp, NSTG + 6);
        io.clr_ovr = 1'b1;
        tick();
        io.clr_ovr = 1'b0;
        check("ovr_clr", int'(io.overrun), 0);

        start(30000, -20000, 0, tp);
        tick(2);
        drive(1'b1, 1'b0, 1234);
        io.clr_ovr = 1'b1;
        tick();
        drive(1'b0, 1'b0, 0);
        io.clr_ovr = 1'b0;
        check("ovr_setwins", int'(io.overrun), 1);
        collect("setwins", 30000, -20000, tp, 3);
        io.clr_ovr = 1'b1;
        tick();
        io.clr_ovr = 1'b0;

        start(45000, 77777, 0, tp);
        while (cyc < tp + NSTG + 2) tick();
        drive(1'b1, 1'b0, 20000);
        tick();
        drive(1'b0, 1'b0, 0);
        check("outq_ovr", int'(io.overrun), 1);
        check("outq_busy", int'(io.busy), 0);
        collect("outq", 45000, 77777, tp, 3);
        io.clr_ovr = 1'b1;
        tick();
        io.clr_ovr = 1'b0;

        start(50000, 0, 0, tp);
        tick(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", int'(io.busy), 0);
        check("midrst_valid", int'(io.out_valid), 0);
        tick(NSTG + 6);
        check("midrst_nout", oq.size(), 0);
        start(-60000, 40000, 0, tp);
        collect("post_rst", -60000, 40000, tp, 3);

        for (int i = 0; i < 30; i++) begin
            m = int'($urandom_range(120000)) - 60000;
            p = DW'($urandom);
            start(m, int'(p), 0, tp);
            collect($sformatf("rnd%0d", i), m, int'(p), tp, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
